fpa_norm_ctl: RTL and testbench
===============================

Name: fpa_norm_ctl

Overview:
Sequencer for the F-PA T register's shift path. It performs two multi-cycle operations on the 40-bit mantissa held in T while tracking an 8-bit two's-complement exponent:
- NORM: left-normalize the mantissa.
- ALIGN: right-align the mantissa by a given count before add/subtract.
It sits beside fpa in the FPU. It drives T shift/clear controls and reads T status flags back. Start/done handshake with the FPU microsequencer.

Parameters:
MANT_W, 40, mantissa width in bits (T register width).
EXP_W, 8, exponent width, two's complement.

Ports:
clk_sys  in  1  system clock; all state changes on rising edge.
clm_  in  1  reset, asynchronous, active-low.
start  in  1  one-cycle request pulse; sampled only in IDLE.
op  in  1  0 = NORM, 1 = ALIGN; latched with start.
exp_in  in  EXP_W  initial exponent; latched with start.
amt  in  8  unsigned right-shift count for ALIGN; latched with start.
t0  in  1  T bit 0 (sign).
t0_t1  in  1  t0 XOR t1; 1 = normalized.
t_nz  in  6  OR-groups of T: {0:1, 2:7, 8:15, 16:23, 24:31, 32:39}.
t_shl  out  1  T shift left one bit this cycle; fill bit from M, ignored here.
t_shr  out  1  T shift right one bit this cycle.
t_1  out  1  bit shifted into T[0] on right shift.
t_clr  out  1  clear T this cycle.
busy  out  1  operation in progress.
done  out  1  one-cycle completion pulse.
exp_out  out  EXP_W  running/final exponent.
zero  out  1  result mantissa is zero.
exp_uf  out  1  exponent underflow (sticky until next start).
exp_of  out  1  exponent overflow (sticky until next start).

Behaviour:
- Reset (clm_ low, async):
  - state = IDLE.
  - All outputs 0, including exp_out = 0.
  - Shift/clear strobes drop immediately; an in-flight operation is abandoned and no done pulse is issued.
- States: IDLE, CHECK, SHL, SHR, CLR, DONE.
- IDLE + start:
  - Latch op, exp_in into exp_out, amt into a shift counter.
  - Clear zero, exp_uf, exp_of; busy = 1; next state CHECK.
  - start while busy is ignored.
- CHECK:
  - Samples the T flags, which are stable one cycle after any T update.
  - T flags are not sampled in any other state.
  - No strobes are asserted in CHECK.
- NORM from CHECK:
  - If t_nz == 0: go to CLR and set exp_out = 0x80 (most negative).
  - Else if t0_t1 = 1: go to DONE.
  - Else if exp_out == 0x80: set exp_uf = 1, go to CLR.
  - Else go to SHL.
- SHL:
  - t_shl = 1 for exactly one cycle; exp_out -= 1; shift count += 1; next state CHECK.
  - When the shift count reaches MANT_W-1, the state after CHECK is forced to DONE.
- ALIGN from CHECK, first visit:
  - amt == 0: go to DONE.
  - amt >= MANT_W: exp_out = exp_in + amt with saturation; go to CLR.
  - Otherwise go to SHR.
- SHR:
  - t_shr = 1 and t_1 = t0 (arithmetic fill); exp_out += 1; counter -= 1.
  - Counter reaches 0: go to DONE; else stay in SHR.
  - Flags are not re-checked during SHR; back-to-back pulses, one shift per cycle.
- Exponent saturation:
  - Increment beyond +127 holds 0x7F and sets exp_of; shifting continues.
  - Decrement below -128 never happens, because the underflow check precedes SHL.
- CLR: t_clr = 1 for one cycle; zero = 1; next state DONE.
- DONE:
  - done = 1 for one cycle; busy = 1 in this cycle; next state IDLE, where busy = 0.
  - exp_out, zero, exp_uf and exp_of hold until the next start.
- Latency:
  - NORM with n shifts: done in cycle 2n+2 after start.
  - ALIGN with 0 < k < 40: done in cycle k+2.
  - CLR paths: done in cycle 3 (ALIGN) or 2n+3 (NORM).
- Strobe exclusivity: at most one of t_shl, t_shr, t_clr is high in any cycle.

Decomposition:
- Shared package fpa_pkg:
  - State encoding.
  - Op codes OP_NORM / OP_ALIGN.
  - MANT_W.
  - EXP_MIN = 0x80 and EXP_MAX = 0x7F.
- One sub-module, fpa_expcnt:
  - Loadable EXP_W up/down counter with saturating add of an 8-bit unsigned value.
  - Outputs for sticky uf/of flags and the at-minimum flag.

Test Plan:
- NORM, T=0x0800000000, exp_in=5:
  - Three t_shl pulses at cycles 2, 4, 6; done at cycle 8.
  - T=0x4000000000, exp_out=2, zero=0.
- NORM, T=0:
  - No t_shl; one t_clr.
  - zero=1, exp_out=0x80, exp_uf=0, done at cycle 3.
- NORM, T=0x0100000000, exp_in=0x81:
  - One t_shl, giving exp 0x80; then exp_uf=1 and t_clr.
  - zero=1, exp_out=0x80.
- ALIGN, T=0xC000000000, amt=4, exp_in=3:
  - Four consecutive t_shr pulses with t_1=1.
  - T=0xFC00000000, exp_out=7, done at cycle 6.
- ALIGN edge cases:
  - amt=45, exp_in=0x10: t_clr, zero=1, exp_out=0x3D.
  - amt=3, exp_in=0x7E: exp_of=1, exp_out=0x7F, three t_shr pulses.
- Control:
  - A second start during busy is ignored.
  - clm_ low during SHR: strobes drop the same cycle, no done pulse, exp_out=0.
  - Next start proceeds normally.

Source files
------------

// File: rtl/fpa_pkg.sv
// Shared definitions for the F-PA T-register shift sequencer: state/op
// encodings, mantissa geometry and exponent limits.
package fpa_pkg;

    localparam int MANT_W = 40;
    localparam int EXP_W  = 8;

    localparam logic [EXP_W-1:0] EXP_MIN = 8'h80;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'h7F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SHL,
        ST_SHR,
        ST_CLR,
        ST_DONE
    } state_t;

    typedef enum logic {
        OP_NORM  = 1'b0,
        OP_ALIGN = 1'b1
    } op_t;

endpackage

// File: rtl/fpa_norm_ctl_if.sv
// Microsequencer handshake plus T-register control/status bundle for fpa_norm_ctl.
interface fpa_norm_ctl_if;
    import fpa_pkg::*;

    logic             start;
    op_t              op;
    logic [EXP_W-1:0] exp_in;
    logic [7:0]       amt;
    logic             t0;
    logic             t0_t1;
    logic [5:0]       t_nz;
    logic             t_shl;
    logic             t_shr;
    logic             t_1;
    logic             t_clr;
    logic             busy;
    logic             done;
    logic [EXP_W-1:0] exp_out;
    logic             zero;
    logic             exp_uf;
    logic             exp_of;

    modport master (
        output start, op, exp_in, amt, t0, t0_t1, t_nz,
        input  t_shl, t_shr, t_1, t_clr, busy, done, exp_out, zero, exp_uf, exp_of
    );

    modport slave (
        input  start, op, exp_in, amt, t0, t0_t1, t_nz,
        output t_shl, t_shr, t_1, t_clr, busy, done, exp_out, zero, exp_uf, exp_of
    );

endinterface

// File: rtl/fpa_expcnt.sv
// Loadable two's-complement exponent counter: decrement, saturating add of an
// unsigned amount, force-to-minimum, with sticky underflow/overflow flags.
module fpa_expcnt
    import fpa_pkg::*;
(
    input  logic             clk_sys,
    input  logic             clm_,
    input  logic             load,
    input  logic [EXP_W-1:0] load_val,
    input  logic             add_en,
    input  logic [7:0]       add_val,
    input  logic             dec_en,
    input  logic             set_min,
    input  logic             set_uf,
    output logic [EXP_W-1:0] exp_val,
    output logic             uf,
    output logic             of,
    output logic             at_min
);

    logic [EXP_W-1:0]        exp_reg;
    logic                    uf_reg;
    logic                    of_reg;
    logic signed [EXP_W+1:0] sum;
    logic                    sat;

    // Two guard bits hold any signed exponent plus an 8-bit unsigned amount.
    assign sum = $signed({{2{exp_reg[EXP_W-1]}}, exp_reg}) + $signed({2'b00, add_val});
    assign sat = (sum > $signed({2'b00, EXP_MAX}));

    always_ff @(posedge clk_sys or negedge clm_) begin
        if (!clm_) begin
            exp_reg <= '0;
            uf_reg  <= 1'b0;
            of_reg  <= 1'b0;
        end else if (load) begin
            exp_reg <= load_val;
            uf_reg  <= 1'b0;
            of_reg  <= 1'b0;
        end else begin
            if (set_min) begin
                exp_reg <= EXP_MIN;
            end else if (add_en) begin
                if (sat) begin
                    exp_reg <= EXP_MAX;
                    of_reg  <= 1'b1;
                end else begin
                    exp_reg <= sum[EXP_W-1:0];
                end
            end else if (dec_en && !at_min) begin
                exp_reg <= exp_reg - {{(EXP_W-1){1'b0}}, 1'b1};
            end
            if (set_uf) begin
                uf_reg <= 1'b1;
            end
        end
    end

    assign exp_val = exp_reg;
    assign uf      = uf_reg;
    assign of      = of_reg;
    assign at_min  = (exp_reg == EXP_MIN);

endmodule

// File: rtl/fpa_norm_ctl.sv
// Sequences T-register shifts for NORM (left-normalize) and ALIGN (arithmetic
// right-align) while tracking the exponent; start/done handshake to the microsequencer.
module fpa_norm_ctl
    import fpa_pkg::*;
(
    input  logic           clk_sys,
    input  logic           clm_,
    fpa_norm_ctl_if.slave  bus
);

    localparam logic [7:0] NORM_LIM  = 8'(MANT_W - 1);
    localparam logic [7:0] ALIGN_LIM = 8'(MANT_W);

    state_t     state_reg;
    op_t        op_reg;
    logic [7:0] cnt_reg;
    logic       t_shl_reg;
    logic       t_shr_reg;
    logic       t_1_reg;
    logic       t_clr_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       zero_reg;

    state_t     check_next;
    logic       start_ok;
    logic       add_en;
    logic [7:0] add_val;
    logic       dec_en;
    logic       set_min;
    logic       set_uf;
    logic       at_min;

    assign start_ok = (state_reg == ST_IDLE) && bus.start;

    // CHECK decisions and exponent commands; T flags are only looked at in CHECK.
    always_comb begin
        check_next = ST_DONE;
        add_en     = 1'b0;
        add_val    = 8'd1;
        dec_en     = 1'b0;
        set_min    = 1'b0;
        set_uf     = 1'b0;
        case (state_reg)
            ST_CHECK: begin
                if (op_reg == OP_NORM) begin
                    if (cnt_reg == NORM_LIM) begin
                        check_next = ST_DONE;
                    end else if (bus.t_nz == 6'd0) begin
                        check_next = ST_CLR;
                        set_min    = 1'b1;
                    end else if (bus.t0_t1) begin
                        check_next = ST_DONE;
                    end else if (at_min) begin
                        check_next = ST_CLR;
                        set_uf     = 1'b1;
                    end else begin
                        check_next = ST_SHL;
                    end
                end else begin
                    if (cnt_reg == 8'd0) begin
                        check_next = ST_DONE;
                    end else if (cnt_reg >= ALIGN_LIM) begin
                        check_next = ST_CLR;
                        add_en     = 1'b1;
                        add_val    = cnt_reg;
                    end else begin
                        check_next = ST_SHR;
                    end
                end
            end
            ST_SHL:  dec_en = 1'b1;
            ST_SHR:  add_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or negedge clm_) begin
        if (!clm_) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_NORM;
            cnt_reg   <= '0;
            t_shl_reg <= 1'b0;
            t_shr_reg <= 1'b0;
            t_1_reg   <= 1'b0;
            t_clr_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            t_shl_reg <= 1'b0;
            t_shr_reg <= 1'b0;
            t_1_reg   <= 1'b0;
            t_clr_reg <= 1'b0;
            done_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_ok) begin
                        op_reg    <= bus.op;
                        cnt_reg   <= (bus.op == OP_ALIGN) ? bus.amt : 8'd0;
                        zero_reg  <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state_reg <= check_next;
                    case (check_next)
                        ST_SHL: t_shl_reg <= 1'b1;
                        ST_SHR: begin
                            t_shr_reg <= 1'b1;
                            t_1_reg   <= bus.t0;
                        end
                        ST_CLR: begin
                            t_clr_reg <= 1'b1;
                            zero_reg  <= 1'b1;
                        end
                        default: done_reg <= 1'b1;
                    endcase
                end
                ST_SHL: begin
                    cnt_reg   <= cnt_reg + 8'd1;
                    state_reg <= ST_CHECK;
                end
                ST_SHR: begin
                    cnt_reg <= cnt_reg - 8'd1;
                    // The sign cannot change under an arithmetic right shift, so the fill is held.
                    if (cnt_reg == 8'd1) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        t_shr_reg <= 1'b1;
                        t_1_reg   <= t_1_reg;
                    end
                end
                ST_CLR: begin
                    state_reg <= ST_DONE;
                    done_reg  <= 1'b1;
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    fpa_expcnt u_expcnt (
        .clk_sys  (clk_sys),
        .clm_     (clm_),
        .load     (start_ok),
        .load_val (bus.exp_in),
        .add_en   (add_en),
        .add_val  (add_val),
        .dec_en   (dec_en),
        .set_min  (set_min),
        .set_uf   (set_uf),
        .exp_val  (bus.exp_out),
        .uf       (bus.exp_uf),
        .of       (bus.exp_of),
        .at_min   (at_min)
    );

    assign bus.t_shl = t_shl_reg;
    assign bus.t_shr = t_shr_reg;
    assign bus.t_1   = t_1_reg;
    assign bus.t_clr = t_clr_reg;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.zero  = zero_reg;

endmodule

// File: tb/tb_fpa_norm_ctl.sv
// Directed bench for fpa_norm_ctl: a behavioural T register answers the shift
// strobes, and hand-computed vectors fix strobe counts, latency and results.
module tb_fpa_norm_ctl;
    import fpa_pkg::*;

    logic clk_sys = 1'b0;
    logic clm_    = 1'b0;
    always #5 clk_sys = ~clk_sys;

    fpa_norm_ctl_if ifc ();

    fpa_norm_ctl dut (
        .clk_sys (clk_sys),
        .clm_    (clm_),
        .bus     (ifc)
    );

    // T register model; MSB of t_model is T bit 0 (sign).
    logic [39:0] t_model;
    logic        t_load;
    logic [39:0] t_load_val;

    always @(posedge clk_sys) begin
        if (t_load)          t_model <= t_load_val;
        else if (ifc.t_clr)  t_model <= '0;
        else if (ifc.t_shl)  t_model <= {t_model[38:0], 1'b0};
        else if (ifc.t_shr)  t_model <= {ifc.t_1, t_model[39:1]};
    end

    assign ifc.t0    = t_model[39];
    assign ifc.t0_t1 = t_model[39] ^ t_model[38];
    assign ifc.t_nz  = {|t_model[7:0], |t_model[15:8], |t_model[23:16],
                        |t_model[31:24], |t_model[37:32], |t_model[39:38]};

    typedef struct {
        op_t         op;
        logic [7:0]  exp_in;
        logic [7:0]  amt;
        logic [39:0] t_in;
        logic [39:0] t_out;
        logic [7:0]  exp_q;
        logic        zero_q;
        logic        uf_q;
        logic        of_q;
        int          done_cyc;
        int          n_shl;
        int          n_shr;
        int          n_t1;
        int          n_clr;
    } vec_t;

    vec_t vecs [13];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Launch one operation, optionally poking a stray start at cycle poke_cyc.
    task automatic run_op(input string tag, input vec_t v, input int poke_cyc);
        int c, dcyc, shl, shr, t1, clr, excl, busy_bad;
        c = 0; dcyc = -1; shl = 0; shr = 0; t1 = 0; clr = 0; excl = 0; busy_bad = 0;
        @(negedge clk_sys);
        ifc.start  = 1'b1;
        ifc.op     = v.op;
        ifc.exp_in = v.exp_in;
        ifc.amt    = v.amt;
        t_load     = 1'b1;
        t_load_val = v.t_in;
        @(posedge clk_sys);
        while (c < 200 && dcyc < 0) begin
            @(negedge clk_sys);
            c++;
            t_load    = 1'b0;
            ifc.start = (c == poke_cyc);
            if (c == poke_cyc) begin
                ifc.op     = OP_NORM;
                ifc.exp_in = 8'h55;
                ifc.amt    = 8'd9;
            end
            shl += int'(ifc.t_shl);
            shr += int'(ifc.t_shr);
            clr += int'(ifc.t_clr);
            if (ifc.t_shr && ifc.t_1) t1++;
            if (int'(ifc.t_shl) + int'(ifc.t_shr) + int'(ifc.t_clr) > 1) excl++;
            if (!ifc.busy) busy_bad++;
            if (ifc.done) dcyc = c;
        end
        ifc.start = 1'b0;
        @(negedge clk_sys);
        check({tag, " done_cycle"}, 64'(dcyc), 64'(v.done_cyc));
        check({tag, " idle busy/done"}, {62'd0, ifc.busy, ifc.done}, 64'd0);
        check({tag, " exp_out"}, 64'(ifc.exp_out), 64'(v.exp_q));
        check({tag, " zero/uf/of"}, {61'd0, ifc.zero, ifc.exp_uf, ifc.exp_of},
              {61'd0, v.zero_q, v.uf_q, v.of_q});
        check({tag, " t_final"}, 64'(t_model), 64'(v.t_out));
        check({tag, " n_shl"}, 64'(shl), 64'(v.n_shl));
        check({tag, " n_shr"}, 64'(shr), 64'(v.n_shr));
        check({tag, " n_t1"}, 64'(t1), 64'(v.n_t1));
        check({tag, " n_clr"}, 64'(clr), 64'(v.n_clr));
        check({tag, " strobe_excl"}, 64'(excl), 64'd0);
        check({tag, " busy_gap"}, 64'(busy_bad), 64'd0);
    endtask

    initial begin
        //           op         exp_in amt     t_in            t_out           exp_q  z  uf of done shl shr t1 clr
        vecs[0]  = '{OP_NORM,  8'h05, 8'd0,   40'h0800000000, 40'h4000000000, 8'h02, 0, 0, 0, 8,  3,  0,  0,  0};
        vecs[1]  = '{OP_NORM,  8'h33, 8'd0,   40'h0000000000, 40'h0000000000, 8'h80, 1, 0, 0, 3,  0,  0,  0,  1};
        vecs[2]  = '{OP_NORM,  8'h81, 8'd0,   40'h0100000000, 40'h0000000000, 8'h80, 1, 1, 0, 5,  1,  0,  0,  1};
        vecs[3]  = '{OP_ALIGN, 8'h03, 8'd4,   40'hC000000000, 40'hFC00000000, 8'h07, 0, 0, 0, 6,  0,  4,  4,  0};
        vecs[4]  = '{OP_ALIGN, 8'h10, 8'd45,  40'h1234500000, 40'h0000000000, 8'h3D, 1, 0, 0, 3,  0,  0,  0,  1};
        vecs[5]  = '{OP_ALIGN, 8'h7E, 8'd3,   40'h4000000000, 40'h0800000000, 8'h7F, 0, 0, 1, 5,  0,  3,  0,  0};
        vecs[6]  = '{OP_NORM,  8'h10, 8'd0,   40'h4000000000, 40'h4000000000, 8'h10, 0, 0, 0, 2,  0,  0,  0,  0};
        vecs[7]  = '{OP_ALIGN, 8'hF0, 8'd0,   40'h8000000000, 40'h8000000000, 8'hF0, 0, 0, 0, 2,  0,  0,  0,  0};
        vecs[8]  = '{OP_NORM,  8'h00, 8'd0,   40'hF000000000, 40'h8000000000, 8'hFD, 0, 0, 0, 8,  3,  0,  0,  0};
        vecs[9]  = '{OP_ALIGN, 8'h90, 8'd200, 40'h0F00000000, 40'h0000000000, 8'h58, 1, 0, 0, 3,  0,  0,  0,  1};
        vecs[10] = '{OP_ALIGN, 8'h00, 8'd39,  40'h8000000000, 40'hFFFFFFFFFF, 8'h27, 0, 0, 0, 41, 0,  39, 39, 0};
        vecs[11] = '{OP_NORM,  8'h50, 8'd0,   40'h0000000001, 40'h4000000000, 8'h2A, 0, 0, 0, 78, 38, 0,  0,  0};
        vecs[12] = '{OP_ALIGN, 8'h00, 8'd40,  40'hABCDEF0123, 40'h0000000000, 8'h28, 1, 0, 0, 3,  0,  0,  0,  1};

        ifc.start  = 1'b0;
        ifc.op     = OP_NORM;
        ifc.exp_in = '0;
        ifc.amt    = '0;
        t_load     = 1'b1;
        t_load_val = '0;

        repeat (2) @(negedge clk_sys);
        check("reset outputs",
              {49'd0, ifc.t_shl, ifc.t_shr, ifc.t_1, ifc.t_clr, ifc.busy, ifc.done,
               ifc.exp_out, ifc.zero, ifc.exp_uf, ifc.exp_of}, 64'd0);
        clm_   = 1'b1;
        t_load = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i], 0);
        end

        // A stray start while busy must not disturb the ALIGN in flight.
        run_op("poke_busy", vecs[3], 2);

        // Asynchronous reset in the middle of a right-shift run.
        begin
            vec_t rv;
            int   n_done;
            rv = '{OP_ALIGN, 8'h20, 8'd10, 40'h8000000000, 40'h0, 8'h0, 0, 0, 0, 0, 0, 0, 0, 0};
            n_done = 0;
            @(negedge clk_sys);
            ifc.start  = 1'b1;
            ifc.op     = rv.op;
            ifc.exp_in = rv.exp_in;
            ifc.amt    = rv.amt;
            t_load     = 1'b1;
            t_load_val = rv.t_in;
            @(negedge clk_sys);
            ifc.start = 1'b0;
            t_load    = 1'b0;
            repeat (2) @(negedge clk_sys);
            check("rst_mid shr active", {62'd0, ifc.t_shr, ifc.t_1}, 64'd3);
            #2 clm_ = 1'b0;
            #1;
            check("rst_mid strobes", {60'd0, ifc.t_shl, ifc.t_shr, ifc.t_1, ifc.t_clr}, 64'd0);
            check("rst_mid exp/busy", {55'd0, ifc.exp_out, ifc.busy}, 64'd0);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk_sys);
                n_done += int'(ifc.done);
            end
            check("rst_mid no done", 64'(n_done), 64'd0);
            clm_ = 1'b1;
        end

        run_op("after_rst", vecs[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
